pc_audio_mixer: RTL



---
 rtl/pc_audio_pkg.sv | 24 ++
 rtl/pc_audio_lpf.sv | 34 +++
 rtl/pc_audio_mixer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_audio_pkg.sv
// Shared types and constants for the PC-8001 audio mixer.
package pc_audio_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACC   = 3'd1,
        SCALE = 3'd2,
        LPF   = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam int unsigned MASTER_UNITY = 3;
    localparam int unsigned MASTER_SHIFT = 2;

    // Accumulator width; a single channel still gets one guard bit.
    function automatic int unsigned acc_w(input int unsigned nch,
                                          input int unsigned in_w,
                                          input int unsigned gain_w);
        int unsigned extra;
        extra = (nch > 1) ? $clog2(nch) : 1;
        return in_w + gain_w + extra;
    endfunction

endpackage

// File: rtl/pc_audio_lpf.sv
// Single-pole IIR smoothing stage: y += (x - y) >>> SHIFT on each enable strobe.
module pc_audio_lpf #(
    parameter int unsigned ACC_W = 10,
    parameter int unsigned SHIFT = 3
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             en,
    input  logic [ACC_W-1:0] x,
    output logic [ACC_W-1:0] y_c
);

    localparam int unsigned Y_W = ACC_W + 2;

    logic signed [Y_W-1:0] y_q;
    logic signed [Y_W-1:0] diff;
    logic signed [Y_W-1:0] y_next;

    // y stays within [0, x_max], so the low ACC_W bits carry the full value
    always_comb begin
        diff   = $signed({2'b00, x}) - y_q;
        y_next = y_q + (diff >>> SHIFT);
        y_c    = y_next[ACC_W-1:0];
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            y_q <= '0;
        end else if (en) begin
            y_q <= y_next;
        end
    end

endmodule

// File: rtl/pc_audio_mixer.sv
// Time-multiplexed NCH-channel audio mixer with per-channel gain, master volume and saturation.
// Optional output low-pass filter enabled by defining PC_AUDIO_MIXER_LPF_EN.
module pc_audio_mixer
    import pc_audio_pkg::*;
#(
    parameter int unsigned NCH       = 3,
    parameter int unsigned IN_W      = 4,
    parameter int unsigned GAIN_W    = 4,
    parameter int unsigned OUT_W     = 16,
    parameter int unsigned LPF_SHIFT = 3
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    input  logic                   ce_sample,
    input  logic [NCH*IN_W-1:0]    ch_data,
    input  logic [NCH-1:0]         ch_en,
    input  logic [NCH*GAIN_W-1:0]  ch_gain,
    input  logic [3:0]             master_vol,
    input  logic                   clr_status,
    output logic [OUT_W-1:0]       audio_out,
    output logic                   out_valid,
    output logic                   clip,
    output logic                   overrun,
    output logic                   busy
);

    localparam int unsigned ACC_W  = acc_w(NCH, IN_W, GAIN_W);
    localparam int unsigned PROD_W = IN_W + GAIN_W;
    localparam int unsigned SCL_W  = ACC_W + 4;
    localparam int unsigned IDX_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned PAD_W  = OUT_W - ACC_W;

    state_t                  state_q, state_d;
    logic [NCH*IN_W-1:0]     data_q, data_d;
    logic [NCH-1:0]          en_q, en_d;
    logic [NCH*GAIN_W-1:0]   gain_q, gain_d;
    logic [3:0]              mv_q, mv_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [OUT_W-1:0]        audio_out_d;
    logic                    out_valid_d;
    logic                    clip_d;
    logic                    overrun_d;
    logic                    busy_d;

    logic [IN_W-1:0]         cur_data;
    logic [GAIN_W-1:0]       cur_gain;
    logic [PROD_W-1:0]       cur_prod;
    logic [SCL_W-1:0]        scaled;
    logic                    sat;
    logic [ACC_W-1:0]        t_sat;

`ifdef PC_AUDIO_MIXER_LPF_EN
    logic [ACC_W-1:0]        t_q, t_d;
    logic                    clip_flag_q, clip_flag_d;
    logic                    lpf_en_c;
    logic [ACC_W-1:0]        y_c;

    pc_audio_lpf #(
        .ACC_W (ACC_W),
        .SHIFT (LPF_SHIFT)
    ) u_lpf (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .en      (lpf_en_c),
        .x       (t_q),
        .y_c     (y_c)
    );
`endif

    // Datapath for the channel currently selected and the master-volume scaling
    always_comb begin
        cur_data = data_q[idx_q*IN_W +: IN_W];
        cur_gain = gain_q[idx_q*GAIN_W +: GAIN_W];
        cur_prod = PROD_W'(cur_data) * PROD_W'(cur_gain);
        scaled   = (SCL_W'(acc_q) * SCL_W'({1'b0, mv_q} + 5'd1)) >> MASTER_SHIFT;
        sat      = |scaled[SCL_W-1:ACC_W];
        t_sat    = sat ? {ACC_W{1'b1}} : scaled[ACC_W-1:0];
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        en_d        = en_q;
        gain_d      = gain_q;
        mv_d        = mv_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        audio_out_d = audio_out;
        out_valid_d = 1'b0;
        clip_d      = 1'b0;
        overrun_d   = overrun;
`ifdef PC_AUDIO_MIXER_LPF_EN
        t_d         = t_q;
        clip_flag_d = clip_flag_q;
        lpf_en_c    = 1'b0;
`endif

        // a new overrun event takes priority over a clear in the same cycle
        if (clr_status) begin
            overrun_d = 1'b0;
        end
        if (ce_sample && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (ce_sample) begin
                    data_d  = ch_data;
                    en_d    = ch_en;
                    gain_d  = ch_gain;
                    mv_d    = master_vol;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (en_q[idx_q]) begin
                    acc_d = acc_q + ACC_W'(cur_prod);
                end
                if (idx_q == IDX_W'(NCH - 1)) begin
                    state_d = SCALE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            SCALE: begin
`ifdef PC_AUDIO_MIXER_LPF_EN
                t_d         = t_sat;
                clip_flag_d = sat;
                state_d     = LPF;
`else
                audio_out_d = OUT_W'(t_sat) << PAD_W;
                out_valid_d = 1'b1;
                clip_d      = sat;
                state_d     = OUT;
`endif
            end
`ifdef PC_AUDIO_MIXER_LPF_EN
            LPF: begin
                lpf_en_c    = 1'b1;
                audio_out_d = OUT_W'(y_c) << PAD_W;
                out_valid_d = 1'b1;
                clip_d      = clip_flag_q;
                state_d     = OUT;
            end
`endif
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            data_q      <= '0;
            en_q        <= '0;
            gain_q      <= '0;
            mv_q        <= '0;
            idx_q       <= '0;
            acc_q       <= '0;
            audio_out   <= '0;
            out_valid   <= 1'b0;
            clip        <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
`ifdef PC_AUDIO_MIXER_LPF_EN
            t_q         <= '0;
            clip_flag_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            en_q        <= en_d;
            gain_q      <= gain_d;
            mv_q        <= mv_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            audio_out   <= audio_out_d;
            out_valid   <= out_valid_d;
            clip        <= clip_d;
            overrun     <= overrun_d;
            busy        <= busy_d;
`ifdef PC_AUDIO_MIXER_LPF_EN
            t_q         <= t_d;
            clip_flag_q <= clip_flag_d;
`endif
        end
    end

endmodule
